// File: rtl/sp_pkg.sv
// sp_pkg: shared state encoding and default sizes for the spike-rate wordline encoder
package sp_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 8;
    localparam int DEF_LW    = 16;
endpackage

// File: rtl/sp_phase_acc.sv
// sp_phase_acc: one-channel first-order phase accumulator; pulse is the registered carry-out
module sp_phase_acc #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] rate,
    output logic         pulse
);
    logic [N-1:0] acc;
    // accumulate while enabled; the carry of each add is the wordline pulse for the next cycle
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc   <= '0;
            pulse <= 1'b0;
        end else if (en) begin
            {pulse, acc} <= {1'b0, acc} + {1'b0, rate};
        end else begin
            pulse <= 1'b0;
        end
    end
endmodule

// File: rtl/sp_wl_encoder.sv
// sp_wl_encoder: spike-rate to wordline-pulse encoder with per-channel rate registers
module sp_wl_encoder
    import sp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int LW    = DEF_LW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rate_valid,
    output logic                     rate_ready,
    input  logic [$clog2(WIDTH)-1:0] rate_ch,
    input  logic [N-1:0]             rate_val,
    input  logic                     start,
    input  logic [LW-1:0]            win_len,
    input  logic                     abort,
    output logic [WIDTH-1:0]         wlord,
    output logic                     busy,
    output logic                     done
);
    state_t        state;
    logic [N-1:0]  rate_q [WIDTH];
    logic [LW-1:0] cnt;
    logic [LW-1:0] win_len_q;
    logic          go;
    logic          run_en;

    assign rate_ready = (state == IDLE);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign go         = start && (state == IDLE);
    // abort wins over the accumulate step so the aborting edge already clears wlord
    assign run_en     = (state == RUN) && !abort;

    // rate register file; out-of-range channels are accepted but dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) rate_q[i] <= '0;
        end else if (rate_valid && rate_ready && int'(rate_ch) < WIDTH) begin
            rate_q[rate_ch] <= rate_val;
        end
    end

    // window FSM and cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            win_len_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= (win_len == '0) ? DONE : RUN;
                    cnt       <= '0;
                    win_len_q <= win_len;
                end
                RUN: if (abort) begin
                    state <= IDLE;
                end else begin
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == win_len_q - 1'b1) ? DONE : RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sp_phase_acc #(.N(N)) u_acc (
            .clk   (clk),
            .rst   (rst),
            .clr   (go),
            .en    (run_en),
            .rate  (rate_q[i]),
            .pulse (wlord[i])
        );
    end
endmodule

// File: tb/tb_sp_wl_encoder.sv
// tb_sp_wl_encoder: table, directed and random checks of the wordline encoder against a rate model
module tb_sp_wl_encoder;
    localparam int W  = 24;
    localparam int N  = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rate_valid = 1'b0;
    logic          rate_ready;
    logic [4:0]    rate_ch = '0;
    logic [N-1:0]  rate_val = '0;
    logic          start = 1'b0;
    logic [LW-1:0] win_len = '0;
    logic          abort = 1'b0;
    logic [W-1:0]  wlord;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int rq [W];
    int seen [W];
    logic [W-1:0] adj;

    typedef struct {
        int rate;
        int len;
        int pulses;
    } vec_t;
    vec_t vt [8];

    always #5 clk = ~clk;

    sp_wl_encoder #(.WIDTH(W), .N(N), .LW(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .rate_ch    (rate_ch),
        .rate_val   (rate_val),
        .start      (start),
        .win_len    (win_len),
        .abort      (abort),
        .wlord      (wlord),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // channel i fires on window cycle k when floor(k*r/2^N) steps up
    function automatic logic [W-1:0] exp_wl(input int k);
        logic [W-1:0] e;
        for (int i = 0; i < W; i++) e[i] = ((k * rq[i]) >> N) != (((k - 1) * rq[i]) >> N);
        return e;
    endfunction

    task automatic wr(input int ch, input int val);
        logic [31:0] c, v;
        c = ch;
        v = val;
        rate_valid = 1'b1;
        rate_ch    = c[4:0];
        rate_val   = v[N-1:0];
        tick();
        rate_valid = 1'b0;
        if (ch < W) rq[ch] = val;
    endtask

    task automatic window(input int len, input int ab, input bit disturb);
        logic [W-1:0] prev;
        logic [31:0] l;
        l = len;
        for (int i = 0; i < W; i++) seen[i] = 0;
        adj     = '0;
        prev    = '0;
        start   = 1'b1;
        win_len = l[LW-1:0];
        tick();
        start      = 1'b0;
        rate_valid = 1'b0;
        chk("first_wlord", wlord, 0);
        chk("first_busy", busy, len != 0);
        chk("first_ready", rate_ready, 0);
        if (len == 0) begin
            chk("zero_done", done, 1);
            tick();
            chk("zero_done_clear", done, 0);
            chk("zero_busy", busy, 0);
            chk("zero_wlord", wlord, 0);
            chk("zero_ready", rate_ready, 1);
            return;
        end
        for (int k = 1; k <= len; k++) begin
            if (ab != 0 && k == ab + 1) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_wlord", wlord, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_ready", rate_ready, 1);
                tick();
                chk("abort_no_done", done, 0);
                return;
            end
            if (disturb && k == 3) begin
                chk("run_ready", rate_ready, 0);
                rate_valid = 1'b1;
                rate_ch    = 5'd0;
                rate_val   = 8'd7;
                start      = 1'b1;
            end
            tick();
            rate_valid = 1'b0;
            start      = 1'b0;
            chk("wlord", wlord, exp_wl(k));
            chk("done", done, k == len);
            chk("busy", busy, k < len);
            for (int i = 0; i < W; i++) seen[i] += int'(wlord[i]);
            adj  |= prev & wlord;
            prev  = wlord;
        end
        tick();
        chk("end_wlord", wlord, 0);
        chk("end_done", done, 0);
        chk("end_ready", rate_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < W; i++) rq[i] = 0;
        vt[0] = '{128, 8, 4};
        vt[1] = '{255, 8, 7};
        vt[2] = '{0, 8, 0};
        vt[3] = '{37, 256, 37};
        vt[4] = '{1, 256, 1};
        vt[5] = '{64, 10, 2};
        vt[6] = '{200, 5, 3};
        vt[7] = '{100, 3, 1};

        tick();
        tick();
        rst = 1'b0;
        chk("rst_wlord", wlord, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", rate_ready, 1);

        // reset held mid-window clears everything including rates
        wr(0, 200);
        wr(9, 255);
        start   = 1'b1;
        win_len = 16'd20;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("midrst_wlord", wlord, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", rate_ready, 1);
        for (int i = 0; i < W; i++) rq[i] = 0;
        window(10, 0, 0);
        chk("midrst_ch0_pulses", seen[0], 0);
        chk("midrst_ch9_pulses", seen[9], 0);

        // basic window
        wr(0, 128);
        wr(1, 0);
        wr(2, 255);
        window(8, 0, 0);
        chk("t2_ch0", seen[0], 4);
        chk("t2_ch1", seen[1], 0);
        chk("t2_ch2", seen[2], 7);

        window(0, 0, 0);
        window(8, 3, 0);
        window(8, 0, 1);
        chk("t5_ch0", seen[0], 4);
        window(8, 0, 0);
        chk("t5_ch0_next", seen[0], 4);

        wr(5, 37);
        wr(W, 99);
        window(256, 0, 0);
        chk("t6_ch5", seen[5], 37);
        chk("t6_adjacent", adj[5], 0);
        chk("t6_ch0", seen[0], 128);

        // write lands in the same cycle as start
        rate_valid = 1'b1;
        rate_ch    = 5'd7;
        rate_val   = 8'd200;
        rq[7]      = 200;
        window(5, 0, 0);
        chk("same_cycle_ch7", seen[7], 3);

        for (int i = 0; i < 8; i++) begin
            wr(3, vt[i].rate);
            window(vt[i].len, 0, 0);
            chk("tbl_pulses", seen[3], vt[i].pulses);
        end

        for (int r = 0; r < 10; r++) begin
            int len, ab;
            repeat (3) wr(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
            len = int'($urandom_range(0, 40));
            ab  = (len > 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : 0;
            window(len, ab, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
